// File: rtl/sync_select_if.sv
// Two-phase handshake bundle for sync_select: the upstream request channel r/d
// with its bundled select, and the two downstream channels r1/d1 and r2/d2.
interface sync_select_if;
  logic r;
  logic sel;
  logic d;
  logic r1;
  logic d1;
  logic r2;
  logic d2;

  modport master (
    output r, sel, d1, d2,
    input  d, r1, r2
  );

  modport slave (
    input  r, sel, d1, d2,
    output d, r1, r2
  );
endinterface

// File: rtl/sync_select.sv
// Clocked two-phase select: steers each request toggle on r to channel 1 or 2 by
// sel, returns the chosen channel's acknowledge on d, counts completions, flags errors.
module sync_select #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  sync_select_if.slave     bus,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] r_sync, d1_sync, d2_sync;
  logic r_s, d1_s, d2_s;

  logic r_seen, sel_q;
  logic r1_q, r2_q, d_q;

  logic pending, sel_done, other_ack, err_cond;
  logic start, finish;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync  <= '0;
      d1_sync <= '0;
      d2_sync <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.r};
      d1_sync <= {d1_sync[SYNC_STAGES-2:0], bus.d1};
      d2_sync <= {d2_sync[SYNC_STAGES-2:0], bus.d2};
    end
  end

  assign r_s  = r_sync[SYNC_STAGES-1];
  assign d1_s = d1_sync[SYNC_STAGES-1];
  assign d2_s = d2_sync[SYNC_STAGES-1];

  assign pending   = (r_s != r_seen);
  assign sel_done  = sel_q ? (d2_s == r2_q) : (d1_s == r1_q);
  // An acknowledge phase mismatch on the idle channel can only come from a stray toggle.
  assign other_ack = sel_q ? (d1_s != r1_q) : (d2_s != r2_q);
  assign err_cond  = other_ack || (pending && (state != IDLE));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pending) state_nx = WAIT;
      WAIT:    if (sel_done) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start  = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE:    start  = pending;
      ACK:     finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_seen <= 1'b0;
      sel_q  <= 1'b0;
      r1_q   <= 1'b0;
      r2_q   <= 1'b0;
      d_q    <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
      cnt1   <= '0;
      cnt2   <= '0;
    end else begin
      if (start) begin
        sel_q  <= bus.sel;
        r_seen <= r_s;
        busy   <= 1'b1;
        if (bus.sel) begin
          r2_q <= ~r2_q;
        end else begin
          r1_q <= ~r1_q;
        end
      end
      if (finish) begin
        d_q  <= ~d_q;
        busy <= 1'b0;
        if (sel_q) begin
          if (cnt2 != '1) cnt2 <= cnt2 + 1'b1;
        end else begin
          if (cnt1 != '1) cnt1 <= cnt1 + 1'b1;
        end
      end
      if (err_cond) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.r1 = r1_q;
  assign bus.r2 = r2_q;
  assign bus.d  = d_q;

endmodule

// File: tb/tb_sync_select.sv
// Scoreboard bench for sync_select: stimulus queues the expected output toggles,
// a negedge monitor pops and compares them whenever d, r1 or r2 changes.
module tb_sync_select;

  logic       clk;
  logic       rstn;
  logic       busy;
  logic       err;
  logic [1:0] cnt1;
  logic [1:0] cnt2;

  sync_select_if bus ();

  sync_select #(
    .SYNC_STAGES (2),
    .CNT_W       (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave),
    .busy (busy),
    .err  (err),
    .cnt1 (cnt1),
    .cnt2 (cnt2)
  );

  // kind: 0 = r1 toggle, 1 = r2 toggle, 2 = d toggle
  typedef struct {
    int kind;
    int cyc;
    int c1;
    int c2;
    int busy;
    int err;
  } ev_t;

  ev_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  e_c1, e_c2, e_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int b);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.c1   = e_c1;
    e.c2   = e_c2;
    e.busy = b;
    e.err  = e_err;
    sb.push_back(e);
  endtask

  // Monitor
  logic [2:0] prev = '0;
  logic [2:0] cur;
  always @(negedge clk) begin
    if (!rstn) begin
      prev = '0;
    end else begin
      cur = {bus.d, bus.r2, bus.r1};
      for (int k = 0; k < 3; k++) begin
        if (cur[k] != prev[k]) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_toggle kind=%0d actual=toggle required=none (cycle %0d)", k, cyc);
          end else begin
            ev_t e;
            e = sb.pop_front();
            check("toggle_kind", k, e.kind);
            check("toggle_cycle", cyc, e.cyc);
            check("cnt1_at_toggle", int'(cnt1), e.c1);
            check("cnt2_at_toggle", int'(cnt2), e.c2);
            check("busy_at_toggle", int'(busy), e.busy);
            check("err_at_toggle", int'(err), e.err);
          end
        end
      end
      prev = cur;
    end
  end

  function automatic int sat(input int v);
    return (v == 3) ? 3 : v + 1;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rstn   = 1'b0;
    bus.r  = 1'b0;
    bus.d1 = 1'b0;
    bus.d2 = 1'b0;
    bus.sel = 1'b0;
    sb.delete();
    e_c1 = 0; e_c2 = 0; e_err = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // One full transaction: request, ack by the selected channel, settle.
  task automatic txn(input bit s);
    bus.sel = s;
    @(posedge clk); #1;
    bus.r = ~bus.r;
    push(s ? 1 : 0, cyc + 3, 1);
    repeat (5) @(posedge clk);
    #1;
    if (s) begin
      bus.d2 = ~bus.d2;
      e_c2 = sat(e_c2);
    end else begin
      bus.d1 = ~bus.d1;
      e_c1 = sat(e_c1);
    end
    push(2, cyc + 4, 0);
    repeat (6) @(posedge clk);
  endtask

  int d_before;
  int m;

  initial begin
    rstn = 1'b0;
    bus.r = 1'b0; bus.sel = 1'b0; bus.d1 = 1'b0; bus.d2 = 1'b0;
    e_c1 = 0; e_c2 = 0; e_err = 0;

    // 1: reset held with inputs toggling
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.r = ~bus.r; bus.d1 = ~bus.d1; bus.d2 = ~bus.d2;
      @(negedge clk);
      check("reset_outputs", int'({bus.d, bus.r1, bus.r2, busy, err, cnt1, cnt2}), 0);
    end
    @(posedge clk); #1;
    bus.r = 1'b0; bus.d1 = 1'b0; bus.d2 = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // 2: single channel-1 transaction, latency checked by the monitor
    txn(1'b0);
    check("t2_cnt1", int'(cnt1), 1);
    check("t2_r2_idle", int'(bus.r2), 0);
    check("t2_busy", int'(busy), 0);

    // 3: alternating routing
    do_reset();
    txn(1'b0); txn(1'b1); txn(1'b0); txn(1'b1);
    check("t3_cnt1", int'(cnt1), 2);
    check("t3_cnt2", int'(cnt2), 2);
    check("t3_err", int'(err), 0);
    check("t3_phases", int'({bus.r1, bus.r2, bus.d}), 0);

    // 4: wrong-channel acknowledge
    do_reset();
    bus.sel = 1'b1;
    @(posedge clk); #1;
    bus.r = ~bus.r;
    push(1, cyc + 3, 1);
    repeat (5) @(posedge clk);
    #1;
    d_before = int'(bus.d);
    bus.d1 = ~bus.d1;
    e_err = 1;
    repeat (5) @(posedge clk);
    #1;
    check("t4_err_set", int'(err), 1);
    check("t4_d_held", int'(bus.d), d_before);
    check("t4_busy_held", int'(busy), 1);
    bus.d2 = ~bus.d2;
    e_c2 = 1;
    push(2, cyc + 4, 0);
    repeat (6) @(posedge clk);
    #1;
    check("t4_cnt2", int'(cnt2), 1);
    check("t4_err_sticky", int'(err), 1);

    // 5: counter saturation (2-bit counters)
    do_reset();
    txn(1'b0); txn(1'b0); txn(1'b0);
    check("t5_cnt1_3", int'(cnt1), 3);
    txn(1'b0); txn(1'b0);
    check("t5_cnt1_sat", int'(cnt1), 3);

    // 6a: asynchronous reset while waiting for an acknowledge
    do_reset();
    bus.sel = 1'b0;
    @(posedge clk); #1;
    bus.r = ~bus.r;
    push(0, cyc + 3, 1);
    repeat (5) @(posedge clk);
    #1;
    check("t6_in_wait", int'({bus.r1, busy}), 3);
    rstn = 1'b0;
    bus.r = 1'b0;
    #1;
    check("t6_async_reset", int'({bus.d, bus.r1, bus.r2, busy, err, cnt1, cnt2}), 0);
    sb.delete();
    e_c1 = 0; e_c2 = 0; e_err = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // 6b: second request before the first is acknowledged
    @(posedge clk); #1;
    bus.r = 1'b1;
    push(0, cyc + 3, 1);
    repeat (5) @(posedge clk);
    #1;
    bus.r = 1'b0;
    e_err = 1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_early_err", int'(err), 1);
    check("t6_one_r1", int'(bus.r1), 1);
    bus.d1 = 1'b1;
    m = cyc;
    e_c1 = 1;
    push(2, m + 4, 0);
    push(0, m + 5, 1);
    repeat (7) @(posedge clk);
    #1;
    bus.d1 = 1'b0;
    e_c1 = 2;
    push(2, cyc + 4, 0);
    repeat (6) @(posedge clk);
    #1;
    check("t6_cnt1", int'(cnt1), 2);
    check("t6_phases", int'({bus.r1, bus.d}), 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
